tcam_action_stage: RTL

Match-action stage directly downstream of the TCAM lookup in the data plane. It accepts the TCAM's per-key hit/hit_index result with a valid/ready handshake and translates the index into an action word from a control-plane-written action table; misses get a programmable default action. It keeps saturating per-entry hit counters plus a miss counter, and buffers results in a small output FIFO so the egress consumer can apply backpressure.

---
 rtl/tcam_action_stage.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/tcam_action_stage.sv
// Match-action stage after the TCAM: turns a hit index (or a miss) into an action word,
// keeps saturating hit/miss counters and buffers results for a backpressured consumer.
module tcam_action_stage #(
  parameter  int ENTRIES = 16,
  parameter  int ACT_W   = 32,
  parameter  int META_W  = 16,
  parameter  int CNT_W   = 32,
  parameter  int DEPTH   = 4,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_hit,
  input  logic [IDX_W-1:0]  in_index,
  input  logic [META_W-1:0] in_meta,
  input  logic              act_wr_en,
  input  logic [IDX_W-1:0]  act_wr_addr,
  input  logic [ACT_W-1:0]  act_wr_data,
  input  logic              def_wr_en,
  input  logic [ACT_W-1:0]  def_wr_data,
  input  logic              cnt_rd_en,
  input  logic [IDX_W:0]    cnt_rd_addr,
  input  logic              cnt_rd_clr,
  output logic              cnt_rd_valid,
  output logic [CNT_W-1:0]  cnt_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_hit,
  output logic [IDX_W-1:0]  out_index,
  output logic [ACT_W-1:0]  out_action,
  output logic [META_W-1:0] out_meta
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 2;
  localparam logic [IDX_W:0] MISS_ADDR = (IDX_W+1)'(ENTRIES);

  typedef struct packed {
    logic              hit;
    logic [IDX_W-1:0]  index;
    logic [ACT_W-1:0]  action;
    logic [META_W-1:0] meta;
  } result_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [ACT_W-1:0] act_tbl_r [ENTRIES];
  logic [ACT_W-1:0] def_act_r;
  logic             s1_valid_r;
  result_t          s1_res_r, in_res_s;
  result_t          fifo_mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [PTR_W:0]   fifo_cnt_r;
  logic             out_valid_r;
  result_t          out_res_r;
  logic [CNT_W-1:0] hit_cnt_r [ENTRIES];
  logic [CNT_W-1:0] hit_cnt_nxt_s [ENTRIES];
  logic [CNT_W-1:0] miss_cnt_r, miss_cnt_nxt_s;
  logic             cnt_rd_valid_r;
  logic [CNT_W-1:0] cnt_rd_data_r, cnt_rd_val_s;
  logic [OCC_W-1:0] occ_s;
  logic             in_ready_s, accept_s, pop_s, load_s;

  // Credit check, handshakes and action lookup. The output register counts as a FIFO slot.
  always_comb begin
    occ_s      = OCC_W'(fifo_cnt_r) + OCC_W'(out_valid_r) + OCC_W'(s1_valid_r);
    in_ready_s = (occ_s < OCC_W'(DEPTH));
    accept_s   = in_valid && in_ready_s;
    pop_s      = out_valid_r && out_ready;
    load_s     = (fifo_cnt_r != {(PTR_W+1){1'b0}}) && (!out_valid_r || out_ready);
    in_res_s.hit  = in_hit;
    in_res_s.meta = in_meta;
    if (in_hit) begin
      in_res_s.index  = in_index;
      in_res_s.action = act_tbl_r[in_index];
    end else begin
      in_res_s.index  = {IDX_W{1'b0}};
      in_res_s.action = def_act_r;
    end
  end

  // Control-plane table writes; the S1 capture sees the pre-edge contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) act_tbl_r[i] <= {ACT_W{1'b0}};
      def_act_r <= {ACT_W{1'b0}};
    end else begin
      if (act_wr_en) act_tbl_r[act_wr_addr] <= act_wr_data;
      if (def_wr_en) def_act_r <= def_wr_data;
    end
  end

  // S1 result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_res_r   <= {$bits(result_t){1'b0}};
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) s1_res_r <= in_res_s;
    end
  end

  // FIFO storage; pushes never overflow because in_ready reserves the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) fifo_mem_r[i] <= {$bits(result_t){1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      fifo_cnt_r <= {(PTR_W+1){1'b0}};
    end else begin
      if (s1_valid_r) begin
        fifo_mem_r[wr_ptr_r] <= s1_res_r;
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      if (load_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({s1_valid_r, load_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + (PTR_W+1)'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - (PTR_W+1)'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // Registered head; only replaced when empty or being popped, so it holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_res_r   <= {$bits(result_t){1'b0}};
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_res_r   <= fifo_mem_r[rd_ptr_r];
    end else if (pop_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Counter update: clear from a read-clear first, then a saturating increment.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (cnt_rd_en && cnt_rd_clr && (cnt_rd_addr == (IDX_W+1)'(i))) hit_cnt_nxt_s[i] = {CNT_W{1'b0}};
      else hit_cnt_nxt_s[i] = hit_cnt_r[i];
      if (accept_s && in_hit && (in_index == IDX_W'(i))) hit_cnt_nxt_s[i] = sat_inc(hit_cnt_nxt_s[i]);
      else hit_cnt_nxt_s[i] = hit_cnt_nxt_s[i];
    end
    if (cnt_rd_en && cnt_rd_clr && (cnt_rd_addr == MISS_ADDR)) miss_cnt_nxt_s = {CNT_W{1'b0}};
    else miss_cnt_nxt_s = miss_cnt_r;
    if (accept_s && !in_hit) miss_cnt_nxt_s = sat_inc(miss_cnt_nxt_s);
    else miss_cnt_nxt_s = miss_cnt_nxt_s;
    if (cnt_rd_addr < MISS_ADDR) cnt_rd_val_s = hit_cnt_r[cnt_rd_addr[IDX_W-1:0]];
    else if (cnt_rd_addr == MISS_ADDR) cnt_rd_val_s = miss_cnt_r;
    else cnt_rd_val_s = {CNT_W{1'b0}};
  end

  // Counter state and the registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) hit_cnt_r[i] <= {CNT_W{1'b0}};
      miss_cnt_r     <= {CNT_W{1'b0}};
      cnt_rd_valid_r <= 1'b0;
      cnt_rd_data_r  <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < ENTRIES; i++) hit_cnt_r[i] <= hit_cnt_nxt_s[i];
      miss_cnt_r     <= miss_cnt_nxt_s;
      cnt_rd_valid_r <= cnt_rd_en;
      if (cnt_rd_en) cnt_rd_data_r <= cnt_rd_val_s;
    end
  end

  assign in_ready     = in_ready_s;
  assign cnt_rd_valid = cnt_rd_valid_r;
  assign cnt_rd_data  = cnt_rd_data_r;
  assign out_valid    = out_valid_r;
  assign out_hit      = out_res_r.hit;
  assign out_index    = out_res_r.index;
  assign out_action   = out_res_r.action;
  assign out_meta     = out_res_r.meta;
endmodule
